// File: rtl/matrix_key_scan_pkg.sv
// Shared types for the keypad scanner: FSM states, key code, matrix size.
// Also holds the lowest-low-column helper used when sampling columns.
package piano_key_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_e;

    typedef logic [3:0] key_code_t;

    function automatic logic [1:0] lowest_low(input logic [3:0] cs);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!cs[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/matrix_key_scan_if.sv
// Key event bundle from the keypad scanner to the note/mode controller.
// The scanner drives it through the master modport.
interface matrix_key_scan_if;
    import piano_key_pkg::*;

    key_code_t key_code;
    logic      key_valid;
    logic      key_down;
    logic      key_release;

    modport master (
        output key_code,
        output key_valid,
        output key_down,
        output key_release
    );

    modport slave (
        input key_code,
        input key_valid,
        input key_down,
        input key_release
    );

endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-clk enable every PERIOD clocks.
// Shared between the keypad scanner and the display scanner.
module scan_tick_gen #(
    parameter int PERIOD = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 active-low keypad scanner with press/release debounce and event pulses.
// Optional auto-repeat of key_valid while held: define MATRIX_KEY_REPEAT_EN.
module matrix_key_scan
    import piano_key_pkg::*;
#(
    parameter int SCAN_PERIOD    = 200000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         col_in,
    output logic [3:0]         row_out,
    matrix_key_scan_if.master  key_o
);

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_deb
        $error("DEBOUNCE_SCANS out of range 1..15");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_rep
        $error("REPEAT_SCANS must be at least 1");
    end

    logic tick;

    scan_tick_gen #(.PERIOD(SCAN_PERIOD)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    logic [3:0] col_s1_q;
    logic [3:0] cs_q;

    // Columns idle high through the pull-ups, so the synchronizer resets high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q <= 4'hF;
            cs_q     <= 4'hF;
        end else begin
            col_s1_q <= col_in;
            cs_q     <= col_s1_q;
        end
    end

    state_e    state_q, state_d;
    logic [1:0] r_q, r_d;
    logic [1:0] c_q, c_d;
    logic [3:0] deb_q, deb_d;
    key_code_t code_q, code_d;
    logic      valid_q, valid_d;
    logic      down_q, down_d;
    logic      rel_q, rel_d;

    logic       any_low;
    logic [1:0] low_c;
    logic [3:0] deb_inc;
    logic       rep_pulse;

    assign any_low = ~&cs_q;
    assign low_c   = lowest_low(cs_q);
    assign deb_inc = deb_q + 4'd1;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        deb_d   = deb_q;
        code_d  = code_q;
        valid_d = 1'b0;
        down_d  = down_q;
        rel_d   = 1'b0;
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (any_low) begin
                        c_d   = low_c;
                        deb_d = 4'd1;
                        if (DEB_N == 4'd1) begin
                            code_d  = {r_q, low_c};
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        r_d = r_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (any_low && low_c == c_q) begin
                        deb_d = deb_inc;
                        if (deb_inc == DEB_N) begin
                            code_d  = {r_q, c_q};
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        deb_d   = 4'd0;
                        r_d     = r_q + 2'd1;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (cs_q[c_q]) begin
                        deb_d = 4'd1;
                        if (DEB_N == 4'd1) begin
                            down_d  = 1'b0;
                            rel_d   = 1'b1;
                            r_d     = r_q + 2'd1;
                            state_d = SCAN;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (cs_q[c_q]) begin
                        deb_d = deb_inc;
                        if (deb_inc == DEB_N) begin
                            down_d  = 1'b0;
                            rel_d   = 1'b1;
                            r_d     = r_q + 2'd1;
                            state_d = SCAN;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
            endcase
        end
        valid_d = valid_d | rep_pulse;
    end

`ifdef MATRIX_KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_N = REP_W'(REPEAT_SCANS);

    logic [REP_W-1:0] rep_q, rep_d;

    // A bounce back from RELEASE keeps the count; only scanning or
    // entering RELEASE clears it.
    always_comb begin
        rep_d     = rep_q;
        rep_pulse = 1'b0;
        if (tick) begin
            unique case (state_q)
                HELD: begin
                    if (state_d != HELD) begin
                        rep_d = '0;
                    end else if (rep_q + REP_W'(1) == REP_N) begin
                        rep_d     = '0;
                        rep_pulse = 1'b1;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
                end
                RELEASE: rep_d = rep_q;
                default: rep_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`else
    assign rep_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            r_q     <= 2'd0;
            c_q     <= 2'd0;
            deb_q   <= 4'd0;
            code_q  <= '0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            deb_q   <= deb_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            down_q  <= down_d;
            rel_q   <= rel_d;
        end
    end

    assign row_out           = ~(4'b0001 << r_q);
    assign key_o.key_code    = code_q;
    assign key_o.key_valid   = valid_q;
    assign key_o.key_down    = down_q;
    assign key_o.key_release = rel_q;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Self-checking bench for matrix_key_scan with a behavioural keypad model.
// Expected events come from press/release durations, not scan internals.
module tb_matrix_key_scan;
    import piano_key_pkg::*;

    localparam int SP = 10;
    localparam int DS = 3;
    localparam int RS = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] pressed;

    matrix_key_scan_if kif();

    matrix_key_scan #(
        .SCAN_PERIOD    (SP),
        .DEBOUNCE_SCANS (DS),
        .REPEAT_SCANS   (RS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .col_in  (col_in),
        .row_out (row_out),
        .key_o   (kif)
    );

    always #5 clk = ~clk;

    // Key index = {row, col}; a closed key pulls its column low when its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    int n_chk = 0;
    int n_fail = 0;
    int n_press = 0;
    int n_rep = 0;
    int n_rel = 0;
    logic [3:0] last_code = 4'h0;
    logic prev_down = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_down <= 1'b0;
        end else begin
            if (kif.key_valid) begin
                if (!prev_down) begin
                    n_press   <= n_press + 1;
                    last_code <= kif.key_code;
                end else begin
                    n_rep <= n_rep + 1;
                end
            end
            if (kif.key_release) n_rel <= n_rel + 1;
            prev_down <= kif.key_down;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * SP) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output int found);
        found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (kif.key_valid) begin
                found = 1;
                break;
            end
        end
    endtask

    task automatic wait_rel(input int budget, output int found);
        found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (kif.key_release) begin
                found = 1;
                break;
            end
        end
    endtask

    // Reference: a single-row press long enough to outlast row search plus
    // debounce is reported once as {row, lowest col}; shorter than DS never is.
    function automatic void model(input logic [15:0] mask, input int hold,
                                  output int ep, output int code, output int er);
        ep = 0;
        er = 0;
        code = 0;
        if (mask != 16'h0 && hold >= DS + 5) begin
            ep = 1;
            er = 1;
            for (int k = 15; k >= 0; k--)
                if (mask[k]) code = k;
        end
    endfunction

    typedef struct {
        logic [15:0] mask;
        int hold;
        int gap;
        int exp_press;
        int exp_code;
        int exp_rel;
    } vec_t;

    task automatic run_case(input string nm, input vec_t v);
        int p0, r0;
        p0 = n_press;
        r0 = n_rel;
        pressed = v.mask;
        ticks(v.hold);
        pressed = 16'h0;
        ticks(v.gap);
        chk({nm, " presses"}, n_press - p0, v.exp_press);
        if (v.exp_press == 1) chk({nm, " code"}, int'(last_code), v.exp_code);
        chk({nm, " releases"}, n_rel - r0, v.exp_rel);
    endtask

    initial begin
        vec_t vecs[6];
        int rows_exp[5];
        int found, p0, r0, rp0;
        vec_t rv;
        int row, c1, c2;

        rows_exp = '{14, 13, 11, 7, 14};
        vecs[0] = '{16'h0008, 1, 6, 0, 0, 0};
        vecs[1] = '{16'h0005, 9, 6, 1, 0, 1};
        vecs[2] = '{16'h8000, 9, 6, 1, 15, 1};
        vecs[3] = '{16'h0090, 10, 6, 1, 4, 1};
        vecs[4] = '{16'h0400, 2, 6, 0, 0, 0};
        vecs[5] = '{16'h5000, 8, 7, 1, 12, 1};

        pressed = 16'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset row_out", int'(row_out), 14);
        chk("reset key_code", int'(kif.key_code), 0);
        chk("reset key_valid", int'(kif.key_valid), 0);
        chk("reset key_down", int'(kif.key_down), 0);
        chk("reset key_release", int'(kif.key_release), 0);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            repeat (k == 0 ? 5 : 10) @(negedge clk);
            chk($sformatf("idle row step %0d", k), int'(row_out), rows_exp[k]);
        end
        chk("idle no press", n_press, 0);
        chk("idle key_down", int'(kif.key_down), 0);

        // Row2/col1 press, bounce, competing key, then release.
        p0 = n_press;
        r0 = n_rel;
        pressed = 16'h1 << 9;
        wait_valid(10 * SP, found);
        chk("press9 seen", found, 1);
        chk("press9 code", int'(kif.key_code), 9);
        chk("press9 down", int'(kif.key_down), 1);
        ticks(2);
        pressed = pressed | 16'h0001;
        ticks(3);
        pressed = 16'h1 << 9;
        chk("held other key ignored", n_press - p0, 1);
        pressed = 16'h0;
        ticks(1);
        pressed = 16'h1 << 9;
        ticks(5);
        chk("bounce no release", n_rel - r0, 0);
        chk("bounce no revalid", n_press - p0, 1);
        chk("bounce still down", int'(kif.key_down), 1);
        pressed = 16'h0;
        wait_rel(8 * SP, found);
        chk("release9 seen", found, 1);
        chk("release9 down", int'(kif.key_down), 0);
        chk("release9 code held", int'(kif.key_code), 9);
        chk("release9 next row", int'(row_out), 7);
        ticks(4);
        chk("release9 once", n_rel - r0, 1);

        // Reset while a key is held.
        r0 = n_rel;
        pressed = 16'h1 << 6;
        wait_valid(10 * SP, found);
        chk("press6 seen", found, 1);
        ticks(1);
        rst_n = 1'b0;
        #1;
        chk("mid reset row_out", int'(row_out), 14);
        chk("mid reset code", int'(kif.key_code), 0);
        chk("mid reset down", int'(kif.key_down), 0);
        chk("mid reset valid", int'(kif.key_valid), 0);
        chk("mid reset release", int'(kif.key_release), 0);
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ticks(8);
        chk("mid reset no release", n_rel - r0, 0);

`ifdef MATRIX_KEY_REPEAT_EN
        rp0 = n_rep;
        pressed = 16'h1 << 5;
        wait_valid(10 * SP, found);
        chk("repeat press seen", found, 1);
        repeat (17 * SP + 5) @(negedge clk);
        pressed = 16'h0;
        ticks(6);
        chk("repeat pulses", n_rep - rp0, 3);
`else
        rp0 = 0;
`endif

        foreach (vecs[i]) run_case($sformatf("vec%0d", i), vecs[i]);

        for (int it = 0; it < 24; it++) begin
            row = $urandom_range(0, 3);
            c1 = $urandom_range(0, 3);
            c2 = $urandom_range(0, 3);
            rv.mask = 16'h1 << (row * 4 + c1);
            if ($urandom_range(0, 1) == 1) rv.mask = rv.mask | (16'h1 << (row * 4 + c2));
            rv.hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DS - 1)
                                                  : $urandom_range(DS + 5, DS + 10);
            rv.gap = $urandom_range(6, 9);
            model(rv.mask, rv.hold, rv.exp_press, rv.exp_code, rv.exp_rel);
            run_case($sformatf("rand%0d", it), rv);
        end

`ifndef MATRIX_KEY_REPEAT_EN
        chk("no repeat pulses", n_rep, rp0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
